// File: rtl/alu_link_pkg.sv
// alu_link_pkg: shared frame constants, FSM state enums and the frame checksum helper.
package alu_link_pkg;

    localparam logic [7:0] FRAME_HEADER = 8'hA5;
    localparam int         FRAME_BYTES  = 9;

    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_FINISH} top_state_t;
    typedef enum logic [1:0] {BIT_IDLE, BIT_START, BIT_DATA, BIT_STOP} ser_state_t;

    // Snapshot layout is {A, B, C, 3'b000, Flags}: its seven bytes are frame bytes 1..7.
    function automatic logic [7:0] frame_checksum(input logic [55:0] snap);
        logic [7:0] x;
        x = 8'h00;
        for (int k = 0; k < 7; k++) x ^= snap[8*k +: 8];
        return x;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: 8N1 byte serializer, each bit DIV clocks wide.
// Ports: CLOCK_50 clock, rst async reset, data/valid byte request,
//        ready (may accept a byte this cycle), txd registered line output.
module uart_tx_byte
    import alu_link_pkg::*;
#(
    parameter int DIV = 434
) (
    input  logic       CLOCK_50,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       txd
);
    localparam int CW = $clog2(DIV);

    ser_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    sh_q, sh_d;
    logic          txd_q, txd_d;
    logic          last;

    assign last  = cnt_q == CW'(DIV - 1);
    // Ready in the final stop-bit cycle lets the next start bit follow with no gap.
    assign ready = state_q == BIT_IDLE || (state_q == BIT_STOP && last);
    assign txd   = txd_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = (state_q == BIT_IDLE || last) ? '0 : cnt_q + CW'(1);
        bit_d   = bit_q;
        sh_d    = sh_q;
        txd_d   = txd_q;
        if (valid && ready) begin
            state_d = BIT_START;
            cnt_d   = '0;
            bit_d   = '0;
            sh_d    = data;
            txd_d   = 1'b0;
        end else if (last) begin
            case (state_q)
                BIT_START: begin
                    state_d = BIT_DATA;
                    txd_d   = sh_q[0];
                end
                BIT_DATA: begin
                    if (bit_q == 3'd7) begin
                        state_d = BIT_STOP;
                        txd_d   = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        sh_d  = sh_q >> 1;
                        txd_d = sh_q[1];
                    end
                end
                BIT_STOP: state_d = BIT_IDLE;
                default:  state_d = BIT_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            state_q <= BIT_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            txd_q   <= txd_d;
        end
    end

endmodule

// File: rtl/alu_frame_tx.sv
// alu_frame_tx: snapshots A/B/C/Flags on start and sends a 9-byte checksummed 8N1 frame.
// Ports: CLOCK_50 clock, rst async reset, start request, A/B/C/Flags ALU state,
//        txd UART line, busy frame in flight, done completion pulse, overrun sticky flag.
module alu_frame_tx
    import alu_link_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 115_200
) (
    input  logic        CLOCK_50,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic [15:0] C,
    input  logic [4:0]  Flags,
    output logic        txd,
    output logic        busy,
    output logic        done,
    output logic        overrun
);
    localparam int DIV = (CLK_HZ + BAUD / 2) / BAUD;

    top_state_t  state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [55:0] snap_q, snap_d;
    logic        busy_q, busy_d, done_q, done_d, ovr_q, ovr_d;
    logic        ser_valid, ser_ready;
    logic [7:0]  ser_data, mux_byte;
    logic [3:0]  nxt;
    logic [55:0] snap_sh;

    // idx_q is the byte currently on the line; nxt selects the one to queue behind it.
    assign nxt      = idx_q + 4'd1;
    assign snap_sh  = snap_q << {nxt[2:0] - 3'd1, 3'b000};
    assign mux_byte = nxt == 4'(FRAME_BYTES - 1) ? frame_checksum(snap_q) : snap_sh[55:48];

    assign busy    = busy_q;
    assign done    = done_q;
    assign overrun = ovr_q;

    // The header byte needs no snapshot, so it is handed to the serializer on the
    // accepting edge itself and the start bit appears right after that edge.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        snap_d    = snap_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        ovr_d     = ovr_q | (start & busy_q);
        ser_valid = 1'b0;
        ser_data  = FRAME_HEADER;
        if (state_q == ST_SEND) begin
            if (ser_ready) begin
                if (idx_q == 4'(FRAME_BYTES - 1)) begin
                    state_d = ST_FINISH;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    ser_valid = 1'b1;
                    ser_data  = mux_byte;
                    idx_d     = nxt;
                end
            end
        end else if (start) begin
            state_d   = ST_SEND;
            busy_d    = 1'b1;
            idx_d     = '0;
            snap_d    = {A, B, C, 3'b000, Flags};
            ser_valid = 1'b1;
        end else begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            snap_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
        end
    end

    uart_tx_byte #(.DIV(DIV)) u_ser (
        .CLOCK_50 (CLOCK_50),
        .rst      (rst),
        .data     (ser_data),
        .valid    (ser_valid),
        .ready    (ser_ready),
        .txd      (txd)
    );

endmodule

// File: tb/tb_alu_frame_tx.sv
// tb_alu_frame_tx: table-driven frame checks for alu_frame_tx at DIV=4.
module tb_alu_frame_tx;

    logic        CLOCK_50 = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] a_in = '0, b_in = '0, c_in = '0;
    logic [4:0]  f_in = '0;
    logic        txd, busy, done, overrun;
    int          n_chk = 0, n_err = 0;

    typedef struct {
        logic [15:0] a, b, c;
        logic [4:0]  f;
        int          mode;
        logic [71:0] exp;
    } vec_t;

    vec_t vec[5];

    alu_frame_tx #(.CLK_HZ(1_000_000), .BAUD(250_000)) dut (
        .CLOCK_50 (CLOCK_50),
        .rst      (rst),
        .start    (start),
        .A        (a_in),
        .B        (b_in),
        .C        (c_in),
        .Flags    (f_in),
        .txd      (txd),
        .busy     (busy),
        .done     (done),
        .overrun  (overrun)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input bit ok, input string nm, input logic [71:0] act, input logic [71:0] exp);
        n_chk++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic set_in(input int i);
        a_in = vec[i].a;
        b_in = vec[i].b;
        c_in = vec[i].c;
        f_in = vec[i].f;
    endtask

    // mode 0 plain, 1 inputs change after accept, 2 second start mid-frame,
    // 3 start next vector in the done cycle, 4 frame already launched by mode 3
    task automatic run_frame(input int i);
        logic [359:0] line;
        logic [71:0]  got;
        int           c;
        bit           busy_ok, wid_ok, frm_ok, post_ok;
        line = '1;
        got = '0;
        busy_ok = 1;
        wid_ok = 1;
        frm_ok = 1;
        post_ok = 1;
        if (vec[i].mode != 4) begin
            @(posedge CLOCK_50);
            #1;
            set_in(i);
            start = 1'b1;
        end
        @(posedge CLOCK_50);
        #1;
        start = 1'b0;
        c = 0;
        while (c < 400) begin
            if (done) break;
            if (c < 360) line[c] = txd;
            if (busy !== 1'b1) busy_ok = 0;
            if (vec[i].mode == 1 && c == 0) begin
                a_in = 16'h0000;
                b_in = 16'hAAAA;
                c_in = 16'h5555;
                f_in = 5'h0F;
            end
            if (vec[i].mode == 2 && c == 50) start = 1'b1;
            if (vec[i].mode == 2 && c == 51) start = 1'b0;
            @(posedge CLOCK_50);
            #1;
            c++;
        end
        chk(c == 360, "done_latency", 72'(c), 72'd360);
        chk(busy === 1'b0 && txd === 1'b1, "done_cycle_line", {busy, txd}, 2'b01);
        chk(busy_ok, "busy_during_frame", 72'(busy_ok), 72'd1);
        for (int j = 0; j < 90; j++)
            for (int k = 1; k < 4; k++)
                if (line[4*j+k] !== line[4*j]) wid_ok = 0;
        for (int k = 0; k < 9; k++) begin
            if (line[40*k] !== 1'b0 || line[40*k+36] !== 1'b1) frm_ok = 0;
            for (int b = 0; b < 8; b++) got[8*(8-k)+b] = line[40*k+4*(b+1)];
        end
        chk(wid_ok, "bit_width", 72'(wid_ok), 72'd1);
        chk(frm_ok, "framing", 72'(frm_ok), 72'd1);
        for (int k = 0; k < 9; k++)
            chk(got[8*(8-k) +: 8] === vec[i].exp[8*(8-k) +: 8], $sformatf("v%0d_byte%0d", i, k),
                72'(got[8*(8-k) +: 8]), 72'(vec[i].exp[8*(8-k) +: 8]));
        chk(overrun === (vec[i].mode == 2), "overrun", 72'(overrun), 72'(vec[i].mode == 2));
        if (vec[i].mode == 3) begin
            set_in(i + 1);
            start = 1'b1;
        end else begin
            repeat (20) begin
                @(posedge CLOCK_50);
                #1;
                if (done !== 1'b0 || busy !== 1'b0 || txd !== 1'b1) post_ok = 0;
            end
            chk(post_ok, "post_frame_idle", 72'(post_ok), 72'd1);
        end
    endtask

    initial begin
        bit ok;
        vec[0] = '{16'h1234, 16'h00FF, 16'h1333, 5'h01, 0, 72'hA5_12_34_00_FF_13_33_01_F8};
        vec[1] = '{16'hFFFF, 16'h0102, 16'h0304, 5'h10, 1, 72'hA5_FF_FF_01_02_03_04_10_14};
        vec[2] = '{16'hDEAD, 16'hBEEF, 16'h9D9C, 5'h16, 2, 72'hA5_DE_AD_BE_EF_9D_9C_16_35};
        vec[3] = '{16'h0000, 16'h0000, 16'h0000, 5'h1F, 3, 72'hA5_00_00_00_00_00_00_1F_1F};
        vec[4] = '{16'h8001, 16'h7FFE, 16'h5AA5, 5'h08, 4, 72'hA5_80_01_7F_FE_5A_A5_08_F7};

        repeat (3) @(posedge CLOCK_50);
        #1;
        rst = 1'b0;
        chk(txd === 1'b1 && busy === 1'b0 && done === 1'b0 && overrun === 1'b0, "reset_state",
            {txd, busy, done, overrun}, 4'b1000);
        ok = 1;
        repeat (100) begin
            @(posedge CLOCK_50);
            #1;
            if (txd !== 1'b1 || busy !== 1'b0 || overrun !== 1'b0) ok = 0;
        end
        chk(ok, "idle_100", 72'(ok), 72'd1);

        for (int i = 0; i < 3; i++) run_frame(i);

        rst = 1'b1;
        #1;
        chk(overrun === 1'b0, "overrun_cleared", 72'(overrun), 72'd0);
        @(posedge CLOCK_50);
        #1;
        rst = 1'b0;

        run_frame(3);
        run_frame(4);

        @(posedge CLOCK_50);
        #1;
        set_in(0);
        start = 1'b1;
        @(posedge CLOCK_50);
        #1;
        start = 1'b0;
        repeat (130) @(posedge CLOCK_50);
        #1;
        rst = 1'b1;
        #1;
        chk(txd === 1'b1 && busy === 1'b0, "reset_mid_frame", {txd, busy}, 2'b10);
        @(posedge CLOCK_50);
        #1;
        rst = 1'b0;
        ok = 1;
        repeat (400) begin
            @(posedge CLOCK_50);
            #1;
            if (done !== 1'b0 || busy !== 1'b0 || txd !== 1'b1) ok = 0;
        end
        chk(ok, "no_done_after_abort", 72'(ok), 72'd1);
        run_frame(0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
